// File: rtl/traffic_signal_fsm.sv
// traffic_signal_fsm: RED -> GREEN -> YELLOW Moore traffic-light controller with registered one-hot lamps
// Optional TRAFFIC_SIGNAL_POWERON_INIT_EN gives state, counter and lamps power-on values so no reset is needed.
module traffic_signal_fsm #(
   parameter int RED_CYCLES    = 4,
   parameter int GREEN_CYCLES  = 4,
   parameter int YELLOW_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] light
);
   localparam logic [1:0] S_RED    = 2'd0;
   localparam logic [1:0] S_GREEN  = 2'd1;
   localparam logic [1:0] S_YELLOW = 2'd2;
   localparam logic [15:0] RED_LAST    = 16'(RED_CYCLES - 1);
   localparam logic [15:0] GREEN_LAST  = 16'(GREEN_CYCLES - 1);
   localparam logic [15:0] YELLOW_LAST = 16'(YELLOW_CYCLES - 1);
   if (RED_CYCLES < 1 || RED_CYCLES > 65535 || GREEN_CYCLES < 1 || GREEN_CYCLES > 65535 ||
       YELLOW_CYCLES < 1 || YELLOW_CYCLES > 65535) begin : g_bad_param
      $error("traffic_signal_fsm: phase lengths must be in 1..65535");
   end
`ifdef TRAFFIC_SIGNAL_POWERON_INIT_EN
   logic [1:0]  state   = S_RED;
   logic [15:0] cnt     = '0;
   logic [2:0]  light_q = 3'b100;
`else
   logic [1:0]  state;
   logic [15:0] cnt;
   logic [2:0]  light_q;
`endif
   logic [1:0]  state_n;
   logic [15:0] cnt_n;
   logic [15:0] last;
   logic [2:0]  light_n;
   logic        done;
   logic        illegal;
   assign light = light_q;
   // the lamp register is loaded from the next state so it moves on the same edge as the state
   always_comb begin
      illegal = state == 2'd3;
      last    = state == S_RED ? RED_LAST : state == S_GREEN ? GREEN_LAST : YELLOW_LAST;
      done    = cnt >= last;
      state_n = illegal ? S_RED :
                !done ? state :
                state == S_RED ? S_GREEN :
                state == S_GREEN ? S_YELLOW : S_RED;
      cnt_n   = (illegal || done) ? 16'd0 : cnt + 16'd1;
      light_n = state_n == S_GREEN ? 3'b001 : state_n == S_YELLOW ? 3'b010 : 3'b100;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_RED;
         cnt     <= '0;
         light_q <= 3'b100;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         light_q <= light_n;
      end
   end
endmodule

// File: tb/tb_traffic_signal_fsm.sv
// tb_traffic_signal_fsm: directed vector bench for default and minimum-length traffic_signal_fsm builds
module tb_traffic_signal_fsm;
   typedef struct {
      logic       rst;
      logic [2:0] exp_d;
      logic [2:0] exp_m;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] light_d;
   logic [2:0] light_m;
   int         n_cmp = 0;
   int         n_bad = 0;
   vec_t       vecs [34];
   traffic_signal_fsm u_dut_def (.clk(clk), .rst(rst), .light(light_d));
   traffic_signal_fsm #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1))
      u_dut_min (.clk(clk), .rst(rst), .light(light_m));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask
   initial begin
      int n_r, n_g, n_y, bad_oh;
`ifdef TRAFFIC_SIGNAL_POWERON_INIT_EN
      rst = 1'b0;
      #1;
      chk("poweron_t0_def", int'(light_d), 3'b100);
      chk("poweron_t0_min", int'(light_m), 3'b100);
      repeat (4) @(posedge clk);
      #1;
      chk("poweron_e4_green", int'(light_d), 3'b001);
`else
      rst = 1'b1;
`endif
      vecs = '{
         '{1'b1, 3'b100, 3'b100}, '{1'b1, 3'b100, 3'b100},
         '{1'b0, 3'b100, 3'b001}, '{1'b0, 3'b100, 3'b010}, '{1'b0, 3'b100, 3'b100},
         '{1'b0, 3'b001, 3'b001}, '{1'b0, 3'b001, 3'b010}, '{1'b0, 3'b001, 3'b100}, '{1'b0, 3'b001, 3'b001},
         '{1'b0, 3'b010, 3'b010}, '{1'b0, 3'b010, 3'b100},
         '{1'b0, 3'b100, 3'b001}, '{1'b0, 3'b100, 3'b010}, '{1'b0, 3'b100, 3'b100}, '{1'b0, 3'b100, 3'b001},
         '{1'b0, 3'b001, 3'b010}, '{1'b0, 3'b001, 3'b100}, '{1'b0, 3'b001, 3'b001}, '{1'b0, 3'b001, 3'b010},
         '{1'b0, 3'b010, 3'b100}, '{1'b0, 3'b010, 3'b001},
         '{1'b0, 3'b100, 3'b010}, '{1'b0, 3'b100, 3'b100}, '{1'b0, 3'b100, 3'b001}, '{1'b0, 3'b100, 3'b010},
         '{1'b0, 3'b001, 3'b100}, '{1'b0, 3'b001, 3'b001}, '{1'b0, 3'b001, 3'b010},
         '{1'b1, 3'b100, 3'b100},
         '{1'b0, 3'b100, 3'b001}, '{1'b0, 3'b100, 3'b010}, '{1'b0, 3'b100, 3'b100},
         '{1'b0, 3'b001, 3'b001}, '{1'b0, 3'b001, 3'b010}
      };
      for (int i = 0; i < 34; i++) begin
         rst = vecs[i].rst;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_def", i), int'(light_d), int'(vecs[i].exp_d));
         chk($sformatf("vec%0d_min", i), int'(light_m), int'(vecs[i].exp_m));
      end
      // hold reset several edges mid-GREEN, then the full RED phase must replay
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("hold_rst_def", int'(light_d), 3'b100);
      end
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("post_hold_red", int'(light_d), 3'b100);
      end
      @(posedge clk);
      #1;
      chk("post_hold_green", int'(light_d), 3'b001);
      n_r = 0; n_g = 0; n_y = 0; bad_oh = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (light_d === 3'b100) n_r++;
         else if (light_d === 3'b001) n_g++;
         else if (light_d === 3'b010) n_y++;
         else bad_oh++;
         if (!(light_m === 3'b100 || light_m === 3'b010 || light_m === 3'b001)) bad_oh++;
      end
      chk("long_onehot_viol", bad_oh, 0);
      chk("long_red_cnt", n_r, 400);
      chk("long_green_cnt", n_g, 400);
      chk("long_yellow_cnt", n_y, 200);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
